// File: rtl/mul_div_unit_if.sv
// Handshake bundle between the EX stage and the iterative multiply/divide unit.
// Launch operands go in; busy/done status and the HI/LO registers come back.
interface mul_div_unit_if #(
    parameter int DATA_W = 32
);
    logic              start_in;
    logic [1:0]        op_in;
    logic [DATA_W-1:0] a_in;
    logic [DATA_W-1:0] b_in;
    logic              flush_in;
    logic              busy_out;
    logic              done_out;
    logic              div_by_zero_out;
    logic [DATA_W-1:0] hi_out;
    logic [DATA_W-1:0] lo_out;

    modport master (
        output start_in, op_in, a_in, b_in, flush_in,
        input  busy_out, done_out, div_by_zero_out, hi_out, lo_out
    );

    modport slave (
        input  start_in, op_in, a_in, b_in, flush_in,
        output busy_out, done_out, div_by_zero_out, hi_out, lo_out
    );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers.
// Works on magnitudes for DATA_W iterations, then fixes signs in one extra cycle.
module mul_div_unit #(
    parameter int DATA_W = 32
) (
    input logic           clk,
    input logic           rst,
    mul_div_unit_if.slave bus
);
    localparam int CNT_W = $clog2(DATA_W) + 1;

    typedef enum logic [1:0] {IDLE, BUSY, FIX} state_t;

    state_t              state, state_nx;
    logic [CNT_W-1:0]    count;
    logic [1:0]          op;
    logic                neg_q, neg_r, dz;
    logic [DATA_W-1:0]   acc_hi, acc_lo, dvs;
    logic [DATA_W-1:0]   hi, lo;
    logic                done, dbz;
    logic                launch, last, fin;

    logic                sign_op, sa, sb;
    logic [DATA_W-1:0]   mag_a, mag_b;
    logic [DATA_W:0]     mul_sum, div_shift;
    logic [DATA_W+1:0]   div_diff;
    logic [2*DATA_W-1:0] prod;
    logic [DATA_W-1:0]   quo, rem, hi_nx, lo_nx;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (bus.start_in && !bus.flush_in) state_nx = BUSY;
            BUSY: begin
                if (bus.flush_in) state_nx = IDLE;
                else if (last)    state_nx = FIX;
            end
            FIX:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        launch = (state == IDLE) && bus.start_in && !bus.flush_in;
        last   = (count == CNT_W'(DATA_W - 1));
        fin    = (state == FIX) && !bus.flush_in;
    end

    assign bus.busy_out        = (state != IDLE);
    assign bus.done_out        = done;
    assign bus.div_by_zero_out = dbz;
    assign bus.hi_out          = hi;
    assign bus.lo_out          = lo;

    always_comb begin
        sign_op = ~bus.op_in[0];
        sa      = sign_op & bus.a_in[DATA_W-1];
        sb      = sign_op & bus.b_in[DATA_W-1];
        mag_a   = sa ? -bus.a_in : bus.a_in;
        mag_b   = sb ? -bus.b_in : bus.b_in;
    end

    // Multiply: add multiplicand into upper half on LSB, shift product right.
    // Divide: shift remainder left, subtract divisor, keep if no borrow.
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, dvs} : '0);
        div_shift = {acc_hi, acc_lo[DATA_W-1]};
        div_diff  = {1'b0, div_shift} - {2'b00, dvs};
    end

    always_comb begin
        prod  = neg_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
        quo   = dz ? '1 : (neg_q ? -acc_lo : acc_lo);
        rem   = neg_r ? -acc_hi : acc_hi;
        hi_nx = prod[2*DATA_W-1:DATA_W];
        lo_nx = prod[DATA_W-1:0];
        unique case (1'b1)
            op[1]: begin
                hi_nx = rem;
                lo_nx = quo;
            end
            !op[1]: begin
                hi_nx = prod[2*DATA_W-1:DATA_W];
                lo_nx = prod[DATA_W-1:0];
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= '0;
            op     <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dz     <= 1'b0;
            acc_hi <= '0;
            acc_lo <= '0;
            dvs    <= '0;
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
            dbz    <= 1'b0;
        end else begin
            done <= fin;
            dbz  <= fin & dz;
            if (launch) begin
                op     <= bus.op_in;
                neg_q  <= sa ^ sb;
                neg_r  <= sa;
                dz     <= bus.op_in[1] & (bus.b_in == '0);
                acc_hi <= '0;
                acc_lo <= mag_a;
                dvs    <= mag_b;
                count  <= '0;
            end else if (state == BUSY) begin
                count <= count + CNT_W'(1);
                unique case (1'b1)
                    op[1]: begin
                        if (!div_diff[DATA_W+1]) begin
                            acc_hi <= div_diff[DATA_W-1:0];
                            acc_lo <= {acc_lo[DATA_W-2:0], 1'b1};
                        end else begin
                            acc_hi <= div_shift[DATA_W-1:0];
                            acc_lo <= {acc_lo[DATA_W-2:0], 1'b0};
                        end
                    end
                    !op[1]: {acc_hi, acc_lo} <= {mul_sum, acc_lo[DATA_W-1:1]};
                endcase
            end
            if (fin) begin
                hi <= hi_nx;
                lo <= lo_nx;
            end
        end
    end
endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: scoreboard of expected HI/LO results
// popped on every done_out pulse, plus latency, flush and reset checks.
module tb_mul_div_unit;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mul_div_unit_if #(.DATA_W(W)) bus ();

    mul_div_unit #(.DATA_W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } exp_t;

    exp_t scb[$];
    int   checks = 0;
    int   errors = 0;
    int   dones  = 0;
    int   pushes = 0;

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(logic [1:0] op, logic [W-1:0] a,
                                   logic [W-1:0] b);
        exp_t        e;
        longint      sa, sbv, q, r;
        logic [63:0] p;
        sa   = longint'($signed(a));
        sbv  = longint'($signed(b));
        e.dz = 1'b0;
        p    = '0;
        case (op)
            2'd0: p = sa * sbv;
            2'd1: p = {32'b0, a} * {32'b0, b};
            default: begin
                if (b == '0) begin
                    p    = {a, 32'hFFFF_FFFF};
                    e.dz = 1'b1;
                end else if (op == 2'd2) begin
                    q = sa / sbv;
                    r = sa % sbv;
                    p = {r[31:0], q[31:0]};
                end else begin
                    p = {a % b, a / b};
                end
            end
        endcase
        e.hi = p[63:32];
        e.lo = p[31:0];
        return e;
    endfunction

    always @(negedge clk) begin
        if (bus.done_out) begin
            exp_t e;
            dones++;
            chk("sb_has_entry", 64'(scb.size() != 0), 1);
            if (scb.size() != 0) begin
                e = scb.pop_front();
                chk("sb_hi", bus.hi_out, e.hi);
                chk("sb_lo", bus.lo_out, e.lo);
                chk("sb_dz", bus.div_by_zero_out, e.dz);
            end
        end else if (bus.div_by_zero_out) begin
            chk("dz_without_done", bus.done_out, 1);
        end
    end

    task automatic launch(logic [1:0] op, logic [W-1:0] a, logic [W-1:0] b,
                          bit push);
        bus.op_in    = op;
        bus.a_in     = a;
        bus.b_in     = b;
        bus.start_in = 1'b1;
        if (push) begin
            scb.push_back(model(op, a, b));
            pushes++;
        end
        @(posedge clk);
        #1;
        bus.start_in = 1'b0;
    endtask

    task automatic wait_done(int exp_busy);
        int   n   = 0;
        logic got = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (bus.busy_out) n++;
            else begin
                got = bus.done_out;
                break;
            end
        end
        chk("busy_len", 64'(n), 64'(exp_busy));
        chk("done_at_end", got, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic run(logic [1:0] op, logic [W-1:0] a, logic [W-1:0] b,
                       logic [W-1:0] hi, logic [W-1:0] lo);
        launch(op, a, b, 1'b1);
        wait_done(W + 1);
        chk("hi_value", bus.hi_out, hi);
        chk("lo_value", bus.lo_out, lo);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int d0;
        rst          = 1'b1;
        bus.start_in = 1'b0;
        bus.flush_in = 1'b0;
        bus.op_in    = 2'd0;
        bus.a_in     = '0;
        bus.b_in     = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", bus.busy_out, 0);
        chk("rst_done", bus.done_out, 0);
        chk("rst_dz", bus.div_by_zero_out, 0);
        chk("rst_hi", bus.hi_out, 0);
        chk("rst_lo", bus.lo_out, 0);
        @(posedge clk);
        #1;

        run(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1);
        run(2'd0, 32'hFFFF_FFFD, 32'h5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        run(2'd2, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run(2'd3, 32'h7, 32'h2, 32'h1, 32'h3);
        run(2'd3, 32'h64, 32'h0, 32'h64, 32'hFFFF_FFFF);
        run(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
        run(2'd2, 32'hFFFF_FFF9, 32'h0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);

        // start while busy must be ignored
        d0 = dones;
        launch(2'd1, 32'd6, 32'd7, 1'b1);
        repeat (9) @(posedge clk);
        #1;
        bus.op_in    = 2'd3;
        bus.a_in     = 32'd9;
        bus.b_in     = 32'd3;
        bus.start_in = 1'b1;
        @(posedge clk);
        #1;
        bus.start_in = 1'b0;
        wait_done(23);
        chk("busy_start_hi", bus.hi_out, 0);
        chk("busy_start_lo", bus.lo_out, 32'h2A);
        repeat (3) @(posedge clk);
        #1;
        chk("one_done", 64'(dones - d0), 1);

        // flush mid-BUSY keeps the previous HI/LO
        run(2'd3, 32'd5, 32'd2, 32'h1, 32'h2);
        launch(2'd2, 32'd100, 32'd7, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        bus.flush_in = 1'b1;
        @(posedge clk);
        #1;
        bus.flush_in = 1'b0;
        @(negedge clk);
        chk("flush_busy", bus.busy_out, 0);
        chk("flush_done", bus.done_out, 0);
        chk("flush_hi", bus.hi_out, 32'h1);
        chk("flush_lo", bus.lo_out, 32'h2);
        run(2'd2, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        // flush in the FIX cycle discards the result
        launch(2'd1, 32'd3, 32'd3, 1'b0);
        repeat (32) @(posedge clk);
        #1;
        chk("fix_busy", bus.busy_out, 1);
        bus.flush_in = 1'b1;
        @(posedge clk);
        #1;
        bus.flush_in = 1'b0;
        @(negedge clk);
        chk("fixflush_busy", bus.busy_out, 0);
        chk("fixflush_done", bus.done_out, 0);
        chk("fixflush_hi", bus.hi_out, 32'hFFFF_FFFF);
        chk("fixflush_lo", bus.lo_out, 32'hFFFF_FFFD);
        @(posedge clk);
        #1;

        // reset mid-operation clears HI/LO
        launch(2'd1, 32'hFFFF, 32'hFFFF, 1'b0);
        repeat (11) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_busy", bus.busy_out, 0);
        chk("midrst_done", bus.done_out, 0);
        chk("midrst_hi", bus.hi_out, 0);
        chk("midrst_lo", bus.lo_out, 0);
        @(posedge clk);
        #1;
        bus.op_in    = 2'd1;
        bus.a_in     = 32'd5;
        bus.b_in     = 32'd5;
        bus.start_in = 1'b1;
        bus.flush_in = 1'b1;
        @(posedge clk);
        #1;
        bus.start_in = 1'b0;
        bus.flush_in = 1'b0;
        @(negedge clk);
        chk("startflush_busy", bus.busy_out, 0);
        repeat (40) @(posedge clk);
        #1;
        chk("startflush_lo", bus.lo_out, 0);

        for (int i = 0; i < 8; i++) begin
            logic [1:0]   op;
            logic [W-1:0] a, b;
            op = 2'(i % 4);
            a  = $urandom;
            b  = $urandom;
            if (i >= 4) b = b >> 20;
            if (i == 6) b = '0;
            launch(op, a, b, 1'b1);
            wait_done(W + 1);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", 64'(scb.size()), 0);
        chk("done_count", 64'(dones), 64'(pushes));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
